// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the cache CPU port among NUM_REQ requesters, one access at a time.
// Optional watchdog on the cache handshake enabled by defining CACHE_ARB_TIMEOUT_EN.
module cache_port_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic [DATA_W-1:0]         cache_wdata,
  output logic                      cache_we,
  output logic                      cache_ce,
  input  logic                      cache_ready,
  input  logic [DATA_W-1:0]         cache_rdata
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("cache_port_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                found;
  logic [IDX_W-1:0]    g_sel;

  // Rotating priority search: first active requester at or after ptr_q.
  always_comb begin
    int idx;
    found = 1'b0;
    g_sel = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g_sel = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found && cache_ready) begin
          state_d = S_ISSUE;
          gnt_d   = g_sel;
          addr_d  = req_addr[int'(g_sel)*ADDR_W +: ADDR_W];
          wdata_d = req_wdata[int'(g_sel)*DATA_W +: DATA_W];
          we_d    = req_we[g_sel];
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        ptr_d   = (gnt_q == IDX_W'(NUM_REQ-1)) ? '0 : gnt_q + 1'b1;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!cache_ready) state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (cache_ready) begin
          rdata_d = cache_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef CACHE_ARB_TIMEOUT_EN
    // A genuine completion in the same cycle wins over the watchdog.
    if ((state_q == S_WAIT_LO || state_q == S_WAIT_HI) && state_d != S_RESP) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
        state_d = S_RESP;
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    req_ack     = '0;
    rsp_valid   = '0;
    cache_ce    = (state_q == S_ISSUE);
    busy        = (state_q != S_IDLE);
    cache_addr  = addr_q;
    cache_wdata = wdata_q;
    cache_we    = we_q;
    rsp_rdata   = rdata_q;
    if (state_q == S_ISSUE) req_ack[gnt_q] = 1'b1;
    if (state_q == S_RESP)  rsp_valid[gnt_q] = 1'b1;
`ifdef CACHE_ARB_TIMEOUT_EN
    rsp_err = (state_q == S_RESP) && err_q;
`else
    rsp_err = 1'b0;
`endif
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench for cache_port_arbiter with a behavioural hit/miss cache model.
module tb_cache_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ack, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, cache_wdata, cache_rdata;
  logic [AW-1:0]   cache_addr;
  logic            rsp_err, busy, cache_we, cache_ce, cache_ready;

  cache_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_we(cache_we), .cache_ce(cache_ce), .cache_ready(cache_ready), .cache_rdata(cache_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] data;
    logic          err;
    int            start;
    int            ack_lat;
    int            rsp_lat;
  } txn_t;

  txn_t ack_q[$];
  txn_t rsp_q[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, model_ptr = 0, grants_left = 0;
  bit   hold_mode = 0, hold_lo = 0, stuck = 0, sb_en = 1;

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (a == 32'h0000_0104) return 16'hBEEF;
    if (a == 32'h0000_2200) return 16'h1234;
    return {a[7:0], ~a[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Cache model: ready stays high one cycle after ce, then low 1 (hit) or 3 (miss) cycles.
  int            ph, lat_cnt;
  logic [DW-1:0] pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_ready <= 1'b1; cache_rdata <= '0; ph <= 0; lat_cnt <= 0; pend <= '0;
    end else begin
      case (ph)
        0: begin
          cache_ready <= !hold_lo;
          if (cache_ce) begin
            ph      <= 1;
            lat_cnt <= cache_addr[13] ? 3 : 1;
            pend    <= mem_rd(cache_addr);
          end
        end
        1: begin cache_ready <= 1'b0; ph <= 2; end
        default: if (!stuck) begin
          if (lat_cnt == 1) begin cache_ready <= 1'b1; cache_rdata <= pend; ph <= 0; end
          else lat_cnt <= lat_cnt - 1;
        end
      endcase
    end
  end

  task automatic drive(input int idx, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
    req_addr[idx*AW +: AW]  = a;
    req_wdata[idx*DW +: DW] = wd;
    req_we[idx]             = we;
    req_valid[idx]          = 1'b1;
  endtask

  task automatic push(input int idx, input int ack_lat, input int rsp_lat, input logic err);
    txn_t e;
    e.idx = idx; e.addr = req_addr[idx*AW +: AW]; e.we = req_we[idx];
    e.wdata = req_wdata[idx*DW +: DW]; e.err = err; e.data = err ? '0 : mem_rd(e.addr);
    e.start = cyc; e.ack_lat = ack_lat; e.rsp_lat = rsp_lat;
    ack_q.push_back(e);
    model_ptr = (idx + 1) % N;
  endtask

  task automatic push_mask(input logic [N-1:0] mask);
    logic [N-1:0] m;
    int g, j;
    m = mask;
    while (m != 0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (model_ptr + k) % N;
        if (g < 0 && m[j]) g = j;
      end
      push(g, -1, -1, 1'b0);
      m[g] = 1'b0;
    end
  endtask

  task automatic monitor();
    txn_t e;
    if (req_ack != 0) begin
      if (sb_en) begin
        chk("ack_onehot", 64'($onehot(req_ack)), 1);
        chk("ack_ce", cache_ce, 1);
        if (ack_q.size() == 0) chk("ack_unexpected", req_ack, 0);
        else begin
          e = ack_q.pop_front();
          chk("ack_idx", req_ack, 64'(1) << e.idx);
          chk("ack_addr", cache_addr, e.addr);
          chk("ack_we", cache_we, e.we);
          if (e.we) chk("ack_wdata", cache_wdata, e.wdata);
          if (e.ack_lat >= 0) chk("ack_lat", cyc - e.start, e.ack_lat);
          rsp_q.push_back(e);
        end
      end
      if (hold_mode) begin
        grants_left--;
        if (grants_left == 0) begin req_valid = '0; hold_mode = 0; end
      end else req_valid = req_valid & ~req_ack;
    end else if (sb_en && cache_ce) chk("ce_without_ack", cache_ce, 0);
    if (sb_en && rsp_valid != 0) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_idx", rsp_valid, 64'(1) << e.idx);
        chk("rsp_busy", busy, 1);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_addr_hold", cache_addr, e.addr);
        if (!e.we) chk("rsp_rdata", rsp_rdata, e.data);
        if (e.rsp_lat >= 0) chk("rsp_lat", cyc - e.start, e.rsp_lat);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while ((ack_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, ack_q.size() + rsp_q.size(), 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, n;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_ce", cache_ce, 0);
    chk("rst_addr", cache_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // T1: single hit
    drive(0, 32'h0000_0104, 1'b0, 16'h0);
    push(0, 1, 5, 1'b0);
    wait_done("t1", 20);

    // T2: all four held for eight grants, requester 2 writes
    for (int i = 0; i < N; i++) drive(i, 32'h0000_0100 + 32'(i*8), (i == 2), 16'hC0DE);
    for (int k = 0; k < 8; k++) push(model_ptr, -1, -1, 1'b0);
    hold_mode = 1; grants_left = 8;
    wait_done("t2", 120);
    chk("t2_released", req_valid, 0);

    // T3: miss
    drive(2, 32'h0000_2200, 1'b0, 16'h0);
    push(2, 1, 7, 1'b0);
    wait_done("t3", 20);

    // T4: cache not ready blocks the grant
    hold_lo = 1;
    tick(); tick();
    drive(1, 32'h0000_0040, 1'b0, 16'h0);
    push(1, -1, -1, 1'b0);
    bad = 0;
    repeat (8) begin
      tick();
      if (cache_ce || req_ack != 0) bad++;
    end
    chk("t4_no_grant", bad, 0);
    hold_lo = 0;
    wait_done("t4", 20);

    // T5: reset during WAIT_HI, pending requests re-granted from pointer 0
    sb_en = 0;
    drive(3, 32'h0000_2230, 1'b0, 16'h0);
    drive(1, 32'h0000_2210, 1'b0, 16'h0);
    n = 0;
    while (req_ack == 0 && n < 10) begin tick(); n++; end
    chk("t5_first_ack", n < 10, 1);
    tick(); tick(); tick();
    chk("t5_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ce", cache_ce, 0);
    chk("t5_rst_rsp", rsp_valid, 0);
    chk("t5_rst_addr", cache_addr, 0);
    chk("t5_rst_rdata", rsp_rdata, 0);
    ack_q.delete(); rsp_q.delete();
    drive(3, 32'h0000_2230, 1'b0, 16'h0);
    drive(1, 32'h0000_2210, 1'b0, 16'h0);
    model_ptr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_en = 1;
    push_mask(4'b1010);
    wait_done("t5", 40);

`ifdef CACHE_ARB_TIMEOUT_EN
    // T6: cache never returns ready after ce
    stuck = 1;
    drive(0, 32'h0000_0300, 1'b0, 16'h0);
    push(0, 1, 66, 1'b1);
    wait_done("t6", 200);
    stuck = 0;
    repeat (6) tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
